// File: rtl/riscv_pipe_pkg.sv
// Shared types for the RV32 pipeline hazard/forwarding control.
package riscv_pipe_pkg;

  localparam int REG_ADDR_W_DEF = 5;

  typedef enum logic [1:0] {
    FWD_RF = 2'b00,
    FWD_W  = 2'b01,
    FWD_M  = 2'b10
  } fwd_sel_e;

endpackage

// File: rtl/hazard_scoreboard.sv
// Pending-register scoreboard for multi-cycle ops: one bit per register plus
// an outstanding-op counter, with combinational lookups for the D stage.
module hazard_scoreboard
  import riscv_pipe_pkg::*;
#(
  parameter int REG_ADDR_W  = REG_ADDR_W_DEF,
  parameter int NUM_SRC     = 2,
  parameter int MAX_PENDING = 4
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          i_issue,
  input  logic [REG_ADDR_W-1:0]         i_issue_rd,
  input  logic                          i_retire,
  input  logic [REG_ADDR_W-1:0]         i_retire_rd,
  input  logic [NUM_SRC*REG_ADDR_W-1:0] i_rs,
  input  logic [REG_ADDR_W-1:0]         i_rd,
  output logic [NUM_SRC-1:0]            o_rs_pend,
  output logic                          o_rd_pend,
  output logic                          o_full
);

  localparam int NREG  = 1 << REG_ADDR_W;
  localparam int CNT_W = $clog2(MAX_PENDING + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MAX_PENDING);

  logic [NREG-1:0]  r_pending;
  logic [CNT_W-1:0] r_count;

  logic             w_ret_hit;
  logic             w_iss_ok;
  logic [NREG-1:0]  w_pending_nxt;
  logic [CNT_W-1:0] w_count_nxt;

  // Next-state: a retire only counts if the bit is set; an issue is taken when
  // the target is free (or freed by a same-index retire) and a slot exists.
  always_comb begin
    w_ret_hit     = i_retire && r_pending[i_retire_rd];
    w_iss_ok      = i_issue
                    && (!r_pending[i_issue_rd] || (w_ret_hit && (i_issue_rd == i_retire_rd)))
                    && ((r_count != CNT_MAX) || w_ret_hit);
    w_pending_nxt = r_pending;
    if (w_ret_hit) w_pending_nxt[i_retire_rd] = 1'b0;
    if (w_iss_ok)  w_pending_nxt[i_issue_rd]  = 1'b1;
    w_pending_nxt[0] = 1'b0;
    w_count_nxt = r_count;
    case ({w_iss_ok, w_ret_hit})
      2'b10:   w_count_nxt = r_count + CNT_W'(1);
      2'b01:   w_count_nxt = r_count - CNT_W'(1);
      default: w_count_nxt = r_count;
    endcase
  end

  // Scoreboard state register; reset wins over any same-cycle issue/retire.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_pending <= '0;
      r_count   <= '0;
    end else begin
      r_pending <= w_pending_nxt;
      r_count   <= w_count_nxt;
    end
  end

  // Pending lookups for the D-stage sources/destination and the full flag.
  always_comb begin
    o_rs_pend = '0;
    for (int i = 0; i < NUM_SRC; i++) begin
      o_rs_pend[i] = r_pending[i_rs[i*REG_ADDR_W +: REG_ADDR_W]];
    end
    o_rd_pend = r_pending[i_rd];
    o_full    = (r_count == CNT_MAX);
  end

endmodule

// File: rtl/hazard_ctrl_scoreboard.sv
// Hazard/forwarding control for the 5-stage RV32 pipeline: forward selects,
// stall/flush priority (mem busy > taken branch > D hazard) and scoreboard hookup.
module hazard_ctrl_scoreboard
  import riscv_pipe_pkg::*;
#(
  parameter int REG_ADDR_W  = REG_ADDR_W_DEF,
  parameter int NUM_SRC     = 2,
  parameter int MAX_PENDING = 4
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [NUM_SRC*REG_ADDR_W-1:0] RS_D,
  input  logic [REG_ADDR_W-1:0]         RD_D,
  input  logic                          LongOpD,
  input  logic [NUM_SRC*REG_ADDR_W-1:0] RS_E,
  input  logic [REG_ADDR_W-1:0]         RD_E,
  input  logic                          RegWriteE,
  input  logic                          ResultSrcE0,
  input  logic                          LongOpE,
  input  logic                          PCSrcE,
  input  logic [REG_ADDR_W-1:0]         RD_M,
  input  logic [REG_ADDR_W-1:0]         RD_W,
  input  logic                          RegWriteM,
  input  logic                          RegWriteW,
  input  logic                          MemBusyM,
  input  logic                          LongDoneW,
  input  logic [REG_ADDR_W-1:0]         LongDoneRD,
  output logic [2*NUM_SRC-1:0]          ForwardE,
  output logic                          StallF,
  output logic                          StallD,
  output logic                          StallE,
  output logic                          StallM,
  output logic                          FlushD,
  output logic                          FlushE,
  output logic                          FlushW,
  output logic                          SbFull
);

  logic [NUM_SRC-1:0] w_rs_pend;
  logic               w_rd_pend;
  logic               w_issue;
  logic               w_retire;
  logic               w_haz_d;

  assign w_issue  = LongOpE && RegWriteE && (RD_E != '0) && !StallE;
  assign w_retire = LongDoneW && (LongDoneRD != '0);

  hazard_scoreboard #(
    .REG_ADDR_W  (REG_ADDR_W),
    .NUM_SRC     (NUM_SRC),
    .MAX_PENDING (MAX_PENDING)
  ) u_sb (
    .clk         (clk),
    .rst         (rst),
    .i_issue     (w_issue),
    .i_issue_rd  (RD_E),
    .i_retire    (w_retire),
    .i_retire_rd (LongDoneRD),
    .i_rs        (RS_D),
    .i_rd        (RD_D),
    .o_rs_pend   (w_rs_pend),
    .o_rd_pend   (w_rd_pend),
    .o_full      (SbFull)
  );

  // Per-source forward select; M is the younger result so it beats W.
  always_comb begin
    ForwardE = '0;
    for (int i = 0; i < NUM_SRC; i++) begin
      if (RegWriteM && (RD_M != '0) && (RD_M == RS_E[i*REG_ADDR_W +: REG_ADDR_W]))
        ForwardE[2*i +: 2] = FWD_M;
      else if (RegWriteW && (RD_W != '0) && (RD_W == RS_E[i*REG_ADDR_W +: REG_ADDR_W]))
        ForwardE[2*i +: 2] = FWD_W;
      else
        ForwardE[2*i +: 2] = FWD_RF;
    end
  end

  // D-stage hazard: load-use, long-op use, RAW/WAW on pending regs, full scoreboard.
  always_comb begin
    w_haz_d = 1'b0;
    for (int i = 0; i < NUM_SRC; i++) begin
      if (RS_D[i*REG_ADDR_W +: REG_ADDR_W] != '0) begin
        if (ResultSrcE0 && (RD_E == RS_D[i*REG_ADDR_W +: REG_ADDR_W]))
          w_haz_d = 1'b1;
        if (LongOpE && RegWriteE && (RD_E == RS_D[i*REG_ADDR_W +: REG_ADDR_W]))
          w_haz_d = 1'b1;
      end
      if (w_rs_pend[i]) w_haz_d = 1'b1;
    end
    if (w_rd_pend)          w_haz_d = 1'b1;
    if (LongOpD && SbFull)  w_haz_d = 1'b1;
  end

  // Stall/flush priority; a frozen memory holds everything so a taken branch
  // in E is simply re-resolved once the freeze lifts.
  always_comb begin
    StallF = 1'b0;
    StallD = 1'b0;
    StallE = 1'b0;
    StallM = 1'b0;
    FlushD = 1'b0;
    FlushE = 1'b0;
    FlushW = 1'b0;
    if (MemBusyM) begin
      StallF = 1'b1;
      StallD = 1'b1;
      StallE = 1'b1;
      StallM = 1'b1;
      FlushW = 1'b1;
    end else if (PCSrcE) begin
      FlushD = 1'b1;
      FlushE = 1'b1;
    end else if (w_haz_d) begin
      StallF = 1'b1;
      StallD = 1'b1;
      FlushE = 1'b1;
    end
  end

endmodule

// File: tb/tb_hazard_ctrl_scoreboard.sv
// Directed bench for hazard_ctrl_scoreboard with hand-computed expectations.
module tb_hazard_ctrl_scoreboard;

  logic        clk = 1'b0;
  logic        rst;
  logic [9:0]  RS_D, RS_E;
  logic [4:0]  RD_D, RD_E, RD_M, RD_W, LongDoneRD;
  logic        LongOpD, RegWriteE, ResultSrcE0, LongOpE, PCSrcE;
  logic        RegWriteM, RegWriteW, MemBusyM, LongDoneW;
  logic [3:0]  ForwardE;
  logic        StallF, StallD, StallE, StallM, FlushD, FlushE, FlushW, SbFull;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  hazard_ctrl_scoreboard dut (
    .clk(clk), .rst(rst),
    .RS_D(RS_D), .RD_D(RD_D), .LongOpD(LongOpD),
    .RS_E(RS_E), .RD_E(RD_E), .RegWriteE(RegWriteE), .ResultSrcE0(ResultSrcE0),
    .LongOpE(LongOpE), .PCSrcE(PCSrcE),
    .RD_M(RD_M), .RD_W(RD_W), .RegWriteM(RegWriteM), .RegWriteW(RegWriteW),
    .MemBusyM(MemBusyM), .LongDoneW(LongDoneW), .LongDoneRD(LongDoneRD),
    .ForwardE(ForwardE),
    .StallF(StallF), .StallD(StallD), .StallE(StallE), .StallM(StallM),
    .FlushD(FlushD), .FlushE(FlushE), .FlushW(FlushW), .SbFull(SbFull)
  );

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic idle();
    RS_D = '0; RD_D = '0; LongOpD = 0;
    RS_E = '0; RD_E = '0; RegWriteE = 0; ResultSrcE0 = 0; LongOpE = 0; PCSrcE = 0;
    RD_M = '0; RD_W = '0; RegWriteM = 0; RegWriteW = 0;
    MemBusyM = 0; LongDoneW = 0; LongDoneRD = '0;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic [4:0] rd);
    idle();
    LongOpE = 1; RegWriteE = 1; RD_E = rd;
    tick();
    idle();
  endtask

  // {StallF,StallD,StallE,StallM,FlushD,FlushE,FlushW}
  function automatic logic [6:0] ctl();
    return {StallF, StallD, StallE, StallM, FlushD, FlushE, FlushW};
  endfunction

  initial begin
    idle();
    rst = 1;
    tick(); tick();
    rst = 0;
    #1;
    chk("reset_fwd",   {12'd0, ForwardE}, 16'h0);
    chk("reset_ctl",   {9'd0, ctl()},     16'h0);
    chk("reset_full",  {15'd0, SbFull},   16'h0);

    // forwarding
    RS_E = {5'd0, 5'd5}; RD_M = 5; RegWriteM = 1; RD_W = 5; RegWriteW = 1; #1;
    chk("fwd_m_wins", {12'd0, ForwardE}, 16'b0010);
    RegWriteM = 0; #1;
    chk("fwd_w", {12'd0, ForwardE}, 16'b0001);
    RS_E = {5'd5, 5'd3}; RegWriteM = 1; RD_M = 3; #1;
    chk("fwd_both_src", {12'd0, ForwardE}, 16'b0110);
    RS_E = '0; RD_M = 0; RD_W = 0; #1;
    chk("fwd_x0", {12'd0, ForwardE}, 16'b0000);
    idle();

    // load-use and branch priority
    ResultSrcE0 = 1; RD_E = 7; RS_D = {5'd7, 5'd0}; #1;
    chk("load_use", {9'd0, ctl()}, 16'b1100010);
    PCSrcE = 1; #1;
    chk("branch_over_haz", {9'd0, ctl()}, 16'b0000110);
    PCSrcE = 0; RD_E = 0; RS_D = '0; #1;
    chk("load_use_x0", {9'd0, ctl()}, 16'h0);
    idle();

    // long op x9: long-use in E, then RAW on pending until retire
    LongOpE = 1; RegWriteE = 1; RD_E = 9; RS_D = {5'd0, 5'd9}; #1;
    chk("long_use", {9'd0, ctl()}, 16'b1100010);
    tick();
    idle(); RS_D = {5'd0, 5'd9}; #1;
    chk("raw_pend_9", {15'd0, StallD}, 16'd1);
    tick();
    chk("raw_pend_9_hold", {15'd0, StallD}, 16'd1);
    LongDoneW = 1; LongDoneRD = 9; #1;
    chk("raw_retire_cycle", {15'd0, StallD}, 16'd1);
    tick();
    LongDoneW = 0; #1;
    chk("raw_released", {15'd0, StallD}, 16'd0);
    idle();

    // fill scoreboard x1..x4
    issue(1); issue(2); issue(3); issue(4);
    #1;
    chk("sb_full", {15'd0, SbFull}, 16'd1);
    LongOpD = 1; #1;
    chk("struct_stall", {15'd0, StallD}, 16'd1);
    issue(5);
    LongDoneW = 1; LongDoneRD = 2;
    tick();
    idle(); #1;
    chk("sb_after_retire", {15'd0, SbFull}, 16'd0);
    LongOpD = 1; #1;
    chk("struct_released", {15'd0, StallD}, 16'd0);
    LongOpD = 0; RS_D = {5'd5, 5'd0}; #1;
    chk("issue_when_full_dropped", {15'd0, StallD}, 16'd0);
    RS_D = '0; RD_D = 3; #1;
    chk("waw_pend_3", {15'd0, StallD}, 16'd1);
    idle();

    // pending {1,3,4} count 3 -> add x6, then same-cycle issue/retire x6
    issue(6);
    #1;
    chk("sb_full_x6", {15'd0, SbFull}, 16'd1);
    LongOpE = 1; RegWriteE = 1; RD_E = 6; LongDoneW = 1; LongDoneRD = 6;
    tick();
    idle(); RS_D = {5'd0, 5'd6}; #1;
    chk("same_cycle_pend6", {15'd0, StallD}, 16'd1);
    chk("same_cycle_count", {15'd0, SbFull}, 16'd1);
    LongDoneW = 1; LongDoneRD = 8;
    tick();
    idle(); #1;
    chk("retire_nonpend", {15'd0, SbFull}, 16'd1);
    LongDoneW = 1; LongDoneRD = 6;
    tick();
    idle(); #1;
    chk("retire_x6_count3", {15'd0, SbFull}, 16'd0);

    // memory busy overrides branch and hazard, and blocks issue
    MemBusyM = 1; PCSrcE = 1; RS_D = {5'd0, 5'd1};
    LongOpE = 1; RegWriteE = 1; RD_E = 10; #1;
    chk("membusy_ctl", {9'd0, ctl()}, 16'b1111001);
    tick();
    idle(); RS_D = {5'd0, 5'd10}; #1;
    chk("membusy_no_issue", {15'd0, StallD}, 16'd0);
    PCSrcE = 1; RS_D = '0; #1;
    chk("branch_after_release", {9'd0, ctl()}, 16'b0000110);
    issue(11);
    #1;
    chk("sb_full_x11", {15'd0, SbFull}, 16'd1);

    // reset mid-run with an issue and retire presented
    rst = 1; LongOpE = 1; RegWriteE = 1; RD_E = 12; LongDoneW = 1; LongDoneRD = 1;
    tick();
    rst = 0; idle(); #1;
    chk("rst_full", {15'd0, SbFull}, 16'd0);
    RS_D = {5'd11, 5'd1}; #1;
    chk("rst_pend_cleared", {15'd0, StallD}, 16'd0);
    RS_D = {5'd0, 5'd12}; #1;
    chk("rst_beats_issue", {15'd0, StallD}, 16'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
